// File: rtl/nonce_dispatcher_pkg.sv
// Shared widths, defaults and helpers for the nonce dispatcher slice.
// The FSM state type used by the top level is also defined here.
package nonce_dispatcher_pkg;

    localparam int NONCE_W_DEF    = 32;
    localparam int LANES_DEF      = 4;
    localparam int THROUGHPUT_DEF = 21;
    localparam int INFL_DEPTH_DEF = 16;
    localparam int RES_DEPTH_DEF  = 4;
    localparam int EPOCH_W        = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } disp_state_t;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/nonce_dispatcher_if.sv
// Job/issue/result/output signal bundle between the miner host side and the dispatcher.
// master = host/lanes/consumer side, slave = dispatcher.
interface nonce_dispatcher_if
    import nonce_dispatcher_pkg::*;
#(
    parameter int NONCE_W = NONCE_W_DEF,
    parameter int LANES   = LANES_DEF
) ();

    logic               job_start;
    logic [NONCE_W-1:0] job_nonce;
    logic               issue;
    logic [NONCE_W-1:0] issue_nonce;
    logic               res_valid;
    logic [LANES-1:0]   res_hit;
    logic               out_valid;
    logic               out_ready;
    logic [NONCE_W-1:0] out_nonce;
    logic [LANES-1:0]   out_hits;
    logic               running;
    logic               exhausted;
    logic               res_ovf;
    logic               orphan_err;

    modport master (
        output job_start, job_nonce, res_valid, res_hit, out_ready,
        input  issue, issue_nonce, out_valid, out_nonce, out_hits,
               running, exhausted, res_ovf, orphan_err
    );

    modport slave (
        input  job_start, job_nonce, res_valid, res_hit, out_ready,
        output issue, issue_nonce, out_valid, out_nonce, out_hits,
               running, exhausted, res_ovf, orphan_err
    );

endinterface

// File: rtl/nonce_dispatcher_sync_fifo.sv
// Single-clock FIFO with occupancy count; head is presented combinationally on dout.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo
    import nonce_dispatcher_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [WIDTH-1:0]   din,
    input  logic               pop,
    output logic [WIDTH-1:0]   dout,
    output logic               full,
    output logic               empty,
    output logic [clog2(DEPTH):0] count
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage carries no reset; occupancy pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/nonce_dispatcher.sv
// Nonce issue / result collection controller: paces nonce bases to the hashing lanes,
// tracks them in flight with an epoch tag and queues winning results for transmit.
//
//  state   | meaning
//  --------+------------------------------------------------------
//  ST_IDLE | no job loaded since reset, nothing issued
//  ST_RUN  | issuing a base every THROUGHPUT cycles (stalls when in-flight full)
//  ST_DONE | nonce range wrapped, issuing stopped until next job_start
module nonce_dispatcher
    import nonce_dispatcher_pkg::*;
#(
    parameter int LANES      = LANES_DEF,
    parameter int THROUGHPUT = THROUGHPUT_DEF,
    parameter int NONCE_W    = NONCE_W_DEF,
    parameter int INFL_DEPTH = INFL_DEPTH_DEF,
    parameter int RES_DEPTH  = RES_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    nonce_dispatcher_if.slave bus
);

    localparam int CNT_W  = (THROUGHPUT > 1) ? clog2(THROUGHPUT) : 1;
    localparam int INFL_W = EPOCH_W + NONCE_W;
    localparam int RES_W  = NONCE_W + LANES;

    typedef struct packed {
        logic [EPOCH_W-1:0] epoch;
        logic [NONCE_W-1:0] base;
    } infl_entry_t;

    typedef struct packed {
        logic [NONCE_W-1:0] nonce;
        logic [LANES-1:0]   hits;
    } res_entry_t;

    disp_state_t        state;
    disp_state_t        state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [NONCE_W-1:0] base;
    logic [NONCE_W-1:0] base_inc;
    logic               wrap;
    logic [EPOCH_W-1:0] epoch;
    logic               res_ovf_q;
    logic               orphan_q;

    logic               running;
    logic               exhausted;
    logic               issue_fire;

    infl_entry_t        infl_din;
    infl_entry_t        infl_head;
    logic               infl_full;
    logic               infl_empty;
    logic [clog2(INFL_DEPTH):0] infl_cnt;
    logic               infl_pop;

    res_entry_t         res_din;
    res_entry_t         res_head;
    logic               res_full;
    logic               res_empty;
    logic [clog2(RES_DEPTH):0] res_cnt;
    logic               hit_accept;
    logic               res_push;
    logic               out_pop;

    logic               unused_ok;

    assign {wrap, base_inc} = {1'b0, base} + (NONCE_W+1)'(LANES);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; job_start restarts from any state
    always_comb begin
        state_nxt = state;
        if (bus.job_start)                  state_nxt = ST_RUN;
        else if (issue_fire && wrap)        state_nxt = ST_DONE;
    end

    // Output logic
    always_comb begin
        running    = (state == ST_RUN);
        exhausted  = (state == ST_DONE);
        issue_fire = running && (cnt == '0) && !infl_full && !bus.job_start;
    end

    // Pacing down-counter, base register and epoch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            base  <= '0;
            epoch <= '0;
        end else if (bus.job_start) begin
            cnt   <= '0;
            base  <= bus.job_nonce;
            epoch <= epoch + EPOCH_W'(1);
        end else if (issue_fire) begin
            cnt   <= CNT_W'(THROUGHPUT - 1);
            base  <= base_inc;
        end else if (cnt != '0) begin
            cnt   <= cnt - 1'b1;
        end
    end

    // Results are judged against the register epoch, i.e. before a same-cycle toggle.
    assign infl_din   = '{epoch: epoch, base: base};
    assign infl_pop   = bus.res_valid && !infl_empty;
    assign hit_accept = infl_pop && (infl_head.epoch == epoch) && (|bus.res_hit);
    assign out_pop    = !res_empty && bus.out_ready;
    assign res_push   = hit_accept && (!res_full || out_pop);
    assign res_din    = '{nonce: infl_head.base, hits: bus.res_hit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_ovf_q <= 1'b0;
            orphan_q  <= 1'b0;
        end else begin
            if (hit_accept && res_full && !out_pop) res_ovf_q <= 1'b1;
            if (bus.res_valid && infl_empty)        orphan_q  <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (INFL_W),
        .DEPTH (INFL_DEPTH)
    ) u_infl_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (issue_fire),
        .din   (infl_din),
        .pop   (infl_pop),
        .dout  (infl_head),
        .full  (infl_full),
        .empty (infl_empty),
        .count (infl_cnt)
    );

    sync_fifo #(
        .WIDTH (RES_W),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (res_push),
        .din   (res_din),
        .pop   (out_pop),
        .dout  (res_head),
        .full  (res_full),
        .empty (res_empty),
        .count (res_cnt)
    );

    assign unused_ok = ^{infl_cnt, res_cnt};

    assign bus.issue       = issue_fire;
    assign bus.issue_nonce = base;
    assign bus.out_valid   = !res_empty;
    assign bus.out_nonce   = res_head.nonce;
    assign bus.out_hits    = res_head.hits;
    assign bus.running     = running;
    assign bus.exhausted   = exhausted;
    assign bus.res_ovf     = res_ovf_q;
    assign bus.orphan_err  = orphan_q;

endmodule

// File: tb/tb_nonce_dispatcher.sv
// Randomized and directed bench for nonce_dispatcher against a queue-based model
// that tracks issue times, in-flight bases and queued winners.
module tb_nonce_dispatcher;

    localparam int LANES = 4;
    localparam int TP    = 21;
    localparam int NW    = 32;
    localparam int INFL  = 16;
    localparam int RESD  = 4;

    logic clk;
    logic rst;

    nonce_dispatcher_if #(.NONCE_W(NW), .LANES(LANES)) bus ();

    nonce_dispatcher #(
        .LANES      (LANES),
        .THROUGHPUT (TP),
        .NONCE_W    (NW),
        .INFL_DEPTH (INFL),
        .RES_DEPTH  (RESD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_issue  = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit        ep;
        bit [31:0] base;
    } ent_t;

    typedef struct {
        bit [31:0] nonce;
        bit [3:0]  hits;
    } rent_t;

    ent_t      m_infl[$];
    rent_t     m_res[$];
    bit        m_run, m_exh, m_ep, m_ovf, m_orph;
    bit [31:0] m_base;
    longint    m_cyc, m_next;

    function automatic void model_reset();
        m_infl.delete();
        m_res.delete();
        m_run  = 0;
        m_exh  = 0;
        m_ep   = 0;
        m_ovf  = 0;
        m_orph = 0;
        m_base = 0;
        m_cyc  = 0;
        m_next = 0;
    endfunction

    function automatic bit model_issue();
        return m_run && (m_cyc >= m_next) && (m_infl.size() < INFL) && !bus.job_start;
    endfunction

    task automatic model_step();
        bit    iss;
        bit    opop;
        bit    rpush;
        ent_t  e;
        rent_t rn;
        iss   = model_issue();
        opop  = bus.out_ready && (m_res.size() > 0);
        rpush = 0;
        rn    = '{32'd0, 4'd0};
        if (bus.res_valid) begin
            if (m_infl.size() == 0) m_orph = 1;
            else begin
                e = m_infl.pop_front();
                if (e.ep == m_ep && bus.res_hit != 0) begin
                    rn = '{e.base, bus.res_hit};
                    if (m_res.size() < RESD || opop) rpush = 1;
                    else m_ovf = 1;
                end
            end
        end
        if (opop)  void'(m_res.pop_front());
        if (rpush) m_res.push_back(rn);
        if (bus.job_start) begin
            m_ep   = ~m_ep;
            m_base = bus.job_nonce;
            m_run  = 1;
            m_exh  = 0;
            m_next = m_cyc + 1;
        end else if (iss) begin
            m_infl.push_back('{m_ep, m_base});
            m_next = m_cyc + TP;
            if (longint'(m_base) + LANES > 64'hFFFF_FFFF) begin
                m_run = 0;
                m_exh = 1;
            end
            m_base = m_base + LANES;
        end
        m_cyc++;
    endtask

    task automatic compare_all();
        check_val("issue",       bus.issue,       model_issue());
        check_val("issue_nonce", bus.issue_nonce, m_base);
        check_val("out_valid",   bus.out_valid,   m_res.size() != 0);
        if (m_res.size() != 0) begin
            check_val("out_nonce", bus.out_nonce, m_res[0].nonce);
            check_val("out_hits",  bus.out_hits,  m_res[0].hits);
        end
        check_val("running",    bus.running,    m_run);
        check_val("exhausted",  bus.exhausted,  m_exh);
        check_val("res_ovf",    bus.res_ovf,    m_ovf);
        check_val("orphan_err", bus.orphan_err, m_orph);
    endtask

    // One clock cycle: drive inputs, check mid-cycle, advance model at the edge.
    task automatic cyc(input bit js, input bit [31:0] jn, input bit rv, input bit [3:0] rh,
                       input bit ordy);
        bus.job_start = js;
        bus.job_nonce = jn;
        bus.res_valid = rv;
        bus.res_hit   = rh;
        bus.out_ready = ordy;
        @(negedge clk);
        compare_all();
        if (bus.issue === 1'b1) n_issue++;
        @(posedge clk);
        if (!rst) model_step();
        #1;
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, ordy);
    endtask

    task automatic do_reset_async();
        bus.job_start = 0;
        bus.res_valid = 0;
        bus.res_hit   = 0;
        bus.out_ready = 0;
        #2 rst = 1;
        model_reset();
        #1 compare_all();
        @(posedge clk);
        #1 rst = 0;
    endtask

    initial begin
        int base_iss;
        int n_old;
        int guard;
        bit [31:0] jn;

        bus.job_start = 0;
        bus.job_nonce = 0;
        bus.res_valid = 0;
        bus.res_hit   = 0;
        bus.out_ready = 0;
        rst = 1;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1 rst = 0;

        // 1: pacing from job 0x100
        cyc(1, 32'h100, 0, 0, 1);
        base_iss = n_issue;
        idle(50, 1);
        check_val("p1_issue_cnt", n_issue - base_iss, 3);

        // 2: miss, hit 0100 on the second base, miss
        cyc(0, 0, 1, 4'b0000, 0);
        cyc(0, 0, 1, 4'b0100, 0);
        cyc(0, 0, 0, 0, 0);
        check_val("p2_nonce", bus.out_nonce, 32'h104);
        check_val("p2_hits",  bus.out_hits,  4'b0100);
        cyc(0, 0, 1, 4'b0000, 1);
        idle(3, 1);

        // 3: superseded-epoch results are dropped
        idle(30, 1);
        n_old = m_infl.size();
        cyc(1, 32'h0, 0, 0, 1);
        for (int i = 0; i < n_old; i++) cyc(0, 0, 1, 4'hF, 1);
        idle(2, 1);
        check_val("p3_empty", bus.out_valid, 0);
        cyc(0, 0, 1, 4'b0001, 0);
        cyc(0, 0, 0, 0, 0);
        check_val("p3_nonce", bus.out_nonce, 32'h0);
        idle(3, 1);

        // 4: wrap near the top of the range
        cyc(1, 32'hFFFF_FFF8, 0, 0, 1);
        base_iss = n_issue;
        idle(70, 1);
        check_val("p4_issue_cnt", n_issue - base_iss, 2);
        check_val("p4_exhausted", bus.exhausted, 1);
        guard = 0;
        while (m_infl.size() > 0 && guard < 64) begin
            cyc(0, 0, 1, 4'b0000, 1);
            guard++;
        end
        cyc(1, 32'h1000, 0, 0, 1);
        check_val("p4_exh_clr", bus.exhausted, 0);

        // 5: result FIFO overflow with consumer stalled
        idle(5 * TP + 5, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 4'b1000, 0);
        idle(3, 0);
        check_val("p5_ovf", bus.res_ovf, 1);
        check_val("p5_head", bus.out_nonce, 32'h1000);
        idle(10, 1);

        // 6: in-flight full stalls issuing, then orphan result
        idle(INFL * TP + 40, 1);
        base_iss = n_issue;
        idle(60, 1);
        check_val("p6_stalled", n_issue - base_iss, 0);
        cyc(0, 0, 1, 4'b0000, 1);
        base_iss = n_issue;
        idle(60, 1);
        check_val("p6_release", n_issue - base_iss, 1);
        cyc(1, 32'hFFFF_FFFC, 0, 0, 1);
        guard = 0;
        while ((m_infl.size() > 0 || m_run) && guard < 200) begin
            cyc(0, 0, m_infl.size() > 0, 4'b0000, 1);
            guard++;
        end
        check_val("p6_drain_bound", guard < 200, 1);
        cyc(0, 0, 1, 4'b0000, 1);
        cyc(0, 0, 0, 0, 1);
        check_val("p6_orphan", bus.orphan_err, 1);

        // Randomized traffic with a mid-run async reset
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 2000; i++) begin
                jn = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255) & 8'hFC))
                                                : $urandom;
                cyc($urandom_range(0, 199) == 0, jn,
                    $urandom_range(0, 9) == 0,
                    ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15)),
                    $urandom_range(0, 9) < 7);
            end
            if (pass == 0) do_reset_async();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
